// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - two-wide in-order instruction queue between branch predictor and decode
package ir_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ptaken;
        logic [31:0] ptarget;
    } ir_reg_t;

    localparam ir_reg_t NULL_IR_REG = '0;
endpackage

module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int Depth = 4,
    localparam int CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [1:0]      in_valid_i,
    input  ir_reg_t         in_instr0_i,
    input  ir_reg_t         in_instr1_i,
    output logic [1:0]      ds_rdy_o,
    output logic [1:0]      out_valid_o,
    output ir_reg_t         out_instr0_o,
    output ir_reg_t         out_instr1_o,
    input  logic [1:0]      out_ack_i,
    output logic [CntW-1:0] count_o
);
    localparam int PtrW = $clog2(Depth);
    localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);

    ir_reg_t         r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic            w_wr0, w_wr1, w_rd0, w_rd1;
    logic [PtrW-1:0] w_wr_ptr1, w_rd_ptr1;
    logic [PtrW-1:0] w_wr_step, w_rd_step;
    logic [CntW-1:0] w_wr_n, w_rd_n;

    // Ready looks only at registered occupancy so predictor timing never depends on decode.
    assign ds_rdy_o[0]    = (r_count < DEPTH_C);
    assign ds_rdy_o[1]    = (r_count <= DEPTH_C - CntW'(2));
    assign out_valid_o[0] = (r_count >= CntW'(1));
    assign out_valid_o[1] = (r_count >= CntW'(2));

    assign w_wr0 = in_valid_i[0] & ds_rdy_o[0] & ~flush_i;
    assign w_wr1 = in_valid_i[1] & ds_rdy_o[1] & w_wr0;
    assign w_rd0 = out_ack_i[0] & out_valid_o[0];
    assign w_rd1 = out_ack_i[1] & out_valid_o[1] & w_rd0;

    assign w_wr_ptr1 = r_wr_ptr + PtrW'(1);
    assign w_rd_ptr1 = r_rd_ptr + PtrW'(1);
    assign w_wr_step = PtrW'(w_wr0) + PtrW'(w_wr1);
    assign w_rd_step = PtrW'(w_rd0) + PtrW'(w_rd1);
    assign w_wr_n    = CntW'(w_wr0) + CntW'(w_wr1);
    assign w_rd_n    = CntW'(w_rd0) + CntW'(w_rd1);

    assign out_instr0_o = out_valid_o[0] ? r_mem[r_rd_ptr]  : NULL_IR_REG;
    assign out_instr1_o = out_valid_o[1] ? r_mem[w_rd_ptr1] : NULL_IR_REG;
    assign count_o      = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_wr_step;
            r_rd_ptr <= r_rd_ptr + w_rd_step;
            r_count  <= r_count + w_wr_n - w_rd_n;
        end
    end

    // Payload storage carries no reset; validity comes solely from the count.
    always_ff @(posedge clk_i) begin
        if (w_wr0) r_mem[r_wr_ptr]  <= in_instr0_i;
        if (w_wr1) r_mem[w_wr_ptr1] <= in_instr1_i;
    end
endmodule
